// File: rtl/fifo_6502_multi_if.sv
// CPU-side bus bundle for the multi-channel FIFO peripheral.
// The CPU (master) drives address, write data and direction; the peripheral returns read data and irq.
interface fifo_6502_multi_if #(
  parameter int address_width = 16,
  parameter int data_width    = 8
);
  logic [address_width-1:0] address_i;
  logic [data_width-1:0]    data_i;
  logic [data_width-1:0]    data_o;
  logic                     rd_wr_i;
  logic                     irq_o;

  modport master (output address_i, data_i, rd_wr_i, input data_o, irq_o);
  modport slave  (input address_i, data_i, rd_wr_i, output data_o, irq_o);
endinterface

// File: rtl/fifo_6502_multi.sv
// Memory-mapped multi-channel FIFO peripheral for the 6502 bus: per channel DATA/STATUS/COUNT/THRESH
// registers in a 4-byte window, sticky overflow/underflow flags and an OR-combined level interrupt.
module fifo_6502_multi #(
  parameter int BaseAddress   = 0,
  parameter int NumChannels   = 2,
  parameter int FIFOSize      = 4,
  parameter int address_width = 16,
  parameter int data_width    = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  fifo_6502_multi_if.slave   bus
);
  localparam int DEPTH = 1 << FIFOSize;
  localparam int CW    = FIFOSize + 1;
  localparam int CHW   = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam logic [address_width:0] BASE    = (address_width+1)'(BaseAddress);
  localparam logic [address_width:0] SPAN    = (address_width+1)'(4 * NumChannels);
  localparam logic [CW-1:0]          FULLCNT = CW'(DEPTH);

  logic [data_width-1:0] r_mem    [NumChannels][DEPTH];
  logic [FIFOSize-1:0]   r_rd_ptr [NumChannels];
  logic [FIFOSize-1:0]   r_wr_ptr [NumChannels];
  logic [CW-1:0]         r_count  [NumChannels];
  logic [CW-1:0]         r_thresh [NumChannels];
  logic                  r_ovf    [NumChannels];
  logic                  r_unf    [NumChannels];
  logic [data_width-1:0] r_data_o;
  logic                  r_irq;

  logic [address_width:0] w_addr;
  logic [address_width:0] w_off;
  logic                   w_hit;
  logic [CHW-1:0]         w_ch;
  logic [1:0]             w_reg;
  logic                   w_wr;
  logic [NumChannels-1:0] w_empty;
  logic [NumChannels-1:0] w_full;
  logic [NumChannels-1:0] w_level;
  logic [data_width-1:0]  w_rdata;

  // Decode: one extra address bit keeps the below-base case from wrapping into a window.
  assign w_addr = {1'b0, bus.address_i};
  assign w_off  = w_addr - BASE;
  assign w_hit  = (w_addr >= BASE) && (w_off < SPAN);
  assign w_ch   = w_off[CHW+1:2];
  assign w_reg  = w_off[1:0];
  assign w_wr   = bus.rd_wr_i;

  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      w_empty[c] = (r_count[c] == '0);
      w_full[c]  = (r_count[c] == FULLCNT);
      w_level[c] = (r_thresh[c] != '0) && (r_count[c] >= r_thresh[c]);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_reg)
        2'd0: if (!w_empty[w_ch]) w_rdata = r_mem[w_ch][r_rd_ptr[w_ch]];
        2'd1: w_rdata = data_width'({w_level[w_ch], r_unf[w_ch], r_ovf[w_ch],
                                     w_full[w_ch], w_empty[w_ch]});
        2'd2: w_rdata = data_width'(r_count[w_ch]);
        default: w_rdata = data_width'(r_thresh[w_ch]);
      endcase
    end
  end

  // Register stage: channel state, read data and interrupt all update on the access edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_data_o <= '0;
      r_irq    <= 1'b0;
      for (int c = 0; c < NumChannels; c++) begin
        r_rd_ptr[c] <= '0;
        r_wr_ptr[c] <= '0;
        r_count[c]  <= '0;
        r_thresh[c] <= '0;
        r_ovf[c]    <= 1'b0;
        r_unf[c]    <= 1'b0;
      end
    end else begin
      r_irq <= |w_level;
      if (!w_wr) r_data_o <= w_rdata;
      for (int c = 0; c < NumChannels; c++) begin
        if (w_hit && (w_ch == CHW'(c))) begin
          case (w_reg)
            2'd0: begin
              if (w_wr) begin
                if (w_full[c]) r_ovf[c] <= 1'b1;
                else begin
                  r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
                  r_count[c]  <= r_count[c] + 1'b1;
                end
              end else begin
                if (w_empty[c]) r_unf[c] <= 1'b1;
                else begin
                  r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
                  r_count[c]  <= r_count[c] - 1'b1;
                end
              end
            end
            2'd1: begin
              if (w_wr) begin
                if (bus.data_i[0]) begin
                  r_rd_ptr[c] <= '0;
                  r_wr_ptr[c] <= '0;
                  r_count[c]  <= '0;
                end
                if (bus.data_i[2]) r_ovf[c] <= 1'b0;
                if (bus.data_i[3]) r_unf[c] <= 1'b0;
              end
            end
            2'd3: if (w_wr) r_thresh[c] <= bus.data_i[CW-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Storage is never reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_hit && w_wr && (w_reg == 2'd0) && !w_full[w_ch])
      r_mem[w_ch][r_wr_ptr[w_ch]] <= bus.data_i;
  end

  assign bus.data_o = r_data_o;
  assign bus.irq_o  = r_irq;
endmodule

// File: tb/tb_fifo_6502_multi.sv
// Bench for fifo_6502_multi: directed scenarios plus randomized bus traffic against a queue-based model.
module tb_fifo_6502_multi;
  localparam int NCH = 2;
  localparam logic [15:0] IDLE = 16'hFFF0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_6502_multi_if #(.address_width(16), .data_width(8)) bus ();

  fifo_6502_multi #(
    .BaseAddress(0), .NumChannels(NCH), .FIFOSize(4), .address_width(16), .data_width(8)
  ) dut (
    .clk_i(clk), .reset_i(rst), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mq [NCH][$];
  bit         m_ovf [NCH];
  bit         m_unf [NCH];
  logic [4:0] m_thr [NCH];
  logic [7:0] m_dout;

  function automatic bit m_hit(int c);
    return (m_thr[c] != 5'd0) && (mq[c].size() >= int'(m_thr[c]));
  endfunction

  function automatic bit m_level();
    for (int c = 0; c < NCH; c++) if (m_hit(c)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_status(int c);
    int s;
    s = mq[c].size();
    return {3'b000, m_hit(c), m_unf[c], m_ovf[c], s == 16, s == 0};
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_ovf[c] = 1'b0;
      m_unf[c] = 1'b0;
      m_thr[c] = 5'd0;
    end
    m_dout = 8'h00;
  endtask

  task automatic m_step(input logic [15:0] a, input bit wr, input logic [7:0] d);
    int c;
    int r;
    logic [7:0] v;
    c = int'(a) / 4;
    r = int'(a) % 4;
    v = 8'h00;
    if (int'(a) < 4 * NCH) begin
      if (wr) begin
        case (r)
          0: if (mq[c].size() < 16) mq[c].push_back(d); else m_ovf[c] = 1'b1;
          1: begin
            if (d[0]) mq[c].delete();
            if (d[2]) m_ovf[c] = 1'b0;
            if (d[3]) m_unf[c] = 1'b0;
          end
          3: m_thr[c] = d[4:0];
          default: ;
        endcase
      end else begin
        case (r)
          0: if (mq[c].size() == 0) m_unf[c] = 1'b1; else v = mq[c].pop_front();
          1: v = m_status(c);
          2: v = 8'(mq[c].size());
          default: v = {3'b000, m_thr[c]};
        endcase
      end
    end
    if (!wr) m_dout = v;
  endtask

  // One bus cycle; returns DUT data_o/irq_o after the edge plus model expectations.
  task automatic acc(input logic [15:0] a, input bit wr, input logic [7:0] d,
                     output logic [7:0] got, output logic [7:0] exp,
                     output logic gi, output logic ei);
    ei = m_level();
    m_step(a, wr, d);
    exp = m_dout;
    @(negedge clk);
    bus.address_i = a;
    bus.rd_wr_i   = wr;
    bus.data_i    = d;
    @(posedge clk);
    #1;
    got = bus.data_o;
    gi  = bus.irq_o;
    bus.address_i = IDLE;
    bus.rd_wr_i   = 1'b0;
    bus.data_i    = 8'h00;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] g, e;
    logic gi, ei;
    acc(a, 1'b1, d, g, e, gi, ei);
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] g, output logic gi);
    logic [7:0] e;
    logic ei;
    acc(a, 1'b0, 8'h00, g, e, gi, ei);
  endtask

  task automatic test_reset();
    logic [7:0] g;
    logic gi;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.data_o !== 8'h00) begin n_fail++; $display("FAIL rst_data_o got=%h exp=00", bus.data_o); end
    n_tests++;
    if (bus.irq_o !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b exp=0", bus.irq_o); end
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    rd(16'd1, g, gi);
    n_tests++;
    if (g !== 8'h01) begin n_fail++; $display("FAIL rst_ch0_status got=%h exp=01", g); end
    rd(16'd2, g, gi);
    n_tests++;
    if (g !== 8'h00) begin n_fail++; $display("FAIL rst_ch0_count got=%h exp=00", g); end
    rd(16'd5, g, gi);
    n_tests++;
    if (g !== 8'h01) begin n_fail++; $display("FAIL rst_ch1_status got=%h exp=01", g); end
    n_tests++;
    if (gi !== 1'b0) begin n_fail++; $display("FAIL rst_irq_after got=%b exp=0", gi); end
  endtask

  task automatic test_basic();
    logic [7:0] g;
    logic [7:0] vals [3];
    logic gi;
    vals = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) wr(16'd0, vals[i]);
    for (int i = 0; i < 3; i++) begin
      rd(16'd0, g, gi);
      n_tests++;
      if (g !== vals[i]) begin n_fail++; $display("FAIL basic_pop%0d got=%h exp=%h", i, g, vals[i]); end
    end
    wr(16'h0100, 8'h55);
    n_tests++;
    if (bus.data_o !== 8'h33) begin n_fail++; $display("FAIL write_holds_data_o got=%h exp=33", bus.data_o); end
    rd(16'd2, g, gi);
    n_tests++;
    if (g !== 8'h00) begin n_fail++; $display("FAIL basic_count got=%h exp=00", g); end
    rd(16'd1, g, gi);
    n_tests++;
    if (g !== 8'h01) begin n_fail++; $display("FAIL basic_status got=%h exp=01", g); end
  endtask

  task automatic test_full();
    logic [7:0] g;
    logic gi;
    for (int i = 0; i < 17; i++) begin
      wr(16'd0, 8'(i));
      if (i >= 15) begin
        rd(16'd1, g, gi);
        n_tests++;
        if (g !== ((i == 15) ? 8'h02 : 8'h06)) begin
          n_fail++; $display("FAIL full_status_push%0d got=%h exp=%h", i + 1, g, (i == 15) ? 8'h02 : 8'h06);
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      rd(16'd0, g, gi);
      n_tests++;
      if (g !== 8'(i)) begin n_fail++; $display("FAIL full_pop%0d got=%h exp=%h", i, g, 8'(i)); end
    end
    rd(16'd0, g, gi);
    n_tests++;
    if (g !== 8'h00) begin n_fail++; $display("FAIL underflow_data got=%h exp=00", g); end
    rd(16'd1, g, gi);
    n_tests++;
    if (g !== 8'h0D) begin n_fail++; $display("FAIL sticky_status got=%h exp=0d", g); end
    wr(16'd1, 8'h0C);
    rd(16'd1, g, gi);
    n_tests++;
    if (g !== 8'h01) begin n_fail++; $display("FAIL clear_sticky got=%h exp=01", g); end
  endtask

  task automatic test_wrap();
    logic [7:0] g;
    logic gi;
    for (int i = 0; i < 10; i++) wr(16'd0, 8'(8'h50 + i));
    for (int i = 0; i < 10; i++) rd(16'd0, g, gi);
    for (int i = 0; i < 10; i++) wr(16'd0, 8'(8'hA0 + i));
    for (int i = 0; i < 10; i++) begin
      rd(16'd2, g, gi);
      n_tests++;
      if (g !== 8'(10 - i)) begin n_fail++; $display("FAIL wrap_count%0d got=%h exp=%h", i, g, 8'(10 - i)); end
      rd(16'd0, g, gi);
      n_tests++;
      if (g !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL wrap_pop%0d got=%h exp=%h", i, g, 8'(8'hA0 + i)); end
    end
    rd(16'd2, g, gi);
    n_tests++;
    if (g !== 8'h00) begin n_fail++; $display("FAIL wrap_count_end got=%h exp=00", g); end
  endtask

  task automatic test_irq();
    logic [7:0] g;
    logic gi;
    wr(16'd7, 8'h04);
    for (int i = 0; i < 3; i++) wr(16'd4, 8'(8'hC0 + i));
    rd(IDLE, g, gi);
    n_tests++;
    if (gi !== 1'b0) begin n_fail++; $display("FAIL irq_below got=%b exp=0", gi); end
    wr(16'd4, 8'hC3);
    rd(IDLE, g, gi);
    n_tests++;
    if (gi !== 1'b1) begin n_fail++; $display("FAIL irq_at_thresh got=%b exp=1", gi); end
    rd(16'd5, g, gi);
    n_tests++;
    if (g !== 8'h10) begin n_fail++; $display("FAIL irq_status got=%h exp=10", g); end
    rd(16'd4, g, gi);
    rd(IDLE, g, gi);
    n_tests++;
    if (gi !== 1'b0) begin n_fail++; $display("FAIL irq_after_pop got=%b exp=0", gi); end
    rd(16'd1, g, gi);
    n_tests++;
    if (g !== 8'h01) begin n_fail++; $display("FAIL irq_ch0_isolated got=%h exp=01", g); end
    wr(16'd7, 8'hE4);
    rd(16'd7, g, gi);
    n_tests++;
    if (g !== 8'h04) begin n_fail++; $display("FAIL thresh_upper_bits got=%h exp=04", g); end
    wr(16'd7, 8'h00);
    wr(16'd5, 8'h01);
  endtask

  task automatic test_flush_reset();
    logic [7:0] g;
    logic gi;
    for (int i = 0; i < 5; i++) wr(16'd0, 8'(8'h30 + i));
    wr(16'd1, 8'h01);
    rd(16'd2, g, gi);
    n_tests++;
    if (g !== 8'h00) begin n_fail++; $display("FAIL flush_count got=%h exp=00", g); end
    rd(16'd1, g, gi);
    n_tests++;
    if (g !== 8'h01) begin n_fail++; $display("FAIL flush_status got=%h exp=01", g); end
    wr(16'd7, 8'h02);
    for (int i = 0; i < 4; i++) wr(16'd4, 8'(8'h70 + i));
    rd(16'd4, g, gi);
    n_tests++;
    if (g !== 8'h70 || gi !== 1'b1) begin
      n_fail++; $display("FAIL prereset_state data=%h irq=%b exp data=70 irq=1", g, gi);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.address_i = 16'd4;
    bus.rd_wr_i   = 1'b1;
    bus.data_i    = 8'h5A;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.data_o !== 8'h00 || bus.irq_o !== 1'b0) begin
      n_fail++; $display("FAIL midreset_out data=%h irq=%b exp data=00 irq=0", bus.data_o, bus.irq_o);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.address_i = IDLE;
    bus.rd_wr_i   = 1'b0;
    bus.data_i    = 8'h00;
    m_reset();
    rd(16'd4, g, gi);
    n_tests++;
    if (g !== 8'h00) begin n_fail++; $display("FAIL postreset_pop got=%h exp=00", g); end
    rd(16'd6, g, gi);
    n_tests++;
    if (g !== 8'h00) begin n_fail++; $display("FAIL postreset_count got=%h exp=00", g); end
    rd(16'd7, g, gi);
    n_tests++;
    if (g !== 8'h00) begin n_fail++; $display("FAIL postreset_thresh got=%h exp=00", g); end
    rd(16'd1, g, gi);
    n_tests++;
    if (g !== 8'h01 || gi !== 1'b0) begin
      n_fail++; $display("FAIL postreset_ch0 status=%h irq=%b exp status=01 irq=0", g, gi);
    end
    wr(16'd5, 8'h08);
  endtask

  task automatic test_random();
    logic [7:0] g, e, d;
    logic gi, ei;
    logic [15:0] a;
    bit w;
    int r;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
      a = 16'(4 * $urandom_range(0, NCH - 1) + r);
      if ($urandom_range(0, 19) == 0) a = 16'($urandom_range(4 * NCH, 4 * NCH + 20));
      w = (i % 200 < 110) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      d = 8'($urandom);
      if (w && r == 1) d = (d & 8'h0C) | 8'($urandom_range(0, 7) == 0);
      if (w && r == 3) d = 8'($urandom_range(0, 20)) | (d & 8'hE0);
      acc(a, w, d, g, e, gi, ei);
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL rand_data op%0d a=%h wr=%b got=%h exp=%h", i, a, w, g, e); end
      n_tests++;
      if (gi !== ei) begin n_fail++; $display("FAIL rand_irq op%0d got=%b exp=%b", i, gi, ei); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.address_i = IDLE;
    bus.rd_wr_i   = 1'b0;
    bus.data_i    = 8'h00;
    m_reset();
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_irq();
    test_flush_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
